// File: rtl/ysyx_25020037_hzu.sv
// ysyx_25020037_hzu: issue/hazard scheduler between the IDU and the EXU.
// Instructions issue with zero latency from the IDU to the EXU. An in-order
// scoreboard of in-flight memory ops stalls consumers of pending loads.
// A small FSM sequences a control-flow redirect (flush the front end until
// the PC reloads) and fence.i (drain the LSU, then invalidate the I-cache).
module ysyx_25020037_hzu #(
  parameter int MEM_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         idu_valid,
  output logic                         idu_ready,
  input  logic [4:0]                   id_rs1,
  input  logic [4:0]                   id_rs2,
  input  logic [4:0]                   id_rd,
  input  logic                         id_use_rs1,
  input  logic                         id_use_rs2,
  input  logic                         id_inst_l,
  input  logic                         id_inst_s,
  input  logic                         id_is_fence_i,
  output logic                         exu_issue,
  input  logic                         lsu_ready,
  input  logic                         lsu_valid,
  input  logic                         redirect_valid,
  input  logic                         pc_updata,
  output logic                         fe_flush,
  output logic                         ic_flush_req,
  input  logic                         ic_flush_ack,
  output logic                         hz_stall,
  output logic [$clog2(MEM_DEPTH):0]   mem_outstanding,
  output logic                         sb_err
);

  localparam int PW = $clog2(MEM_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(MEM_DEPTH);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    REDIRECT    = 2'd1,
    FENCE_DRAIN = 2'd2,
    FENCE_FLUSH = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [MEM_DEPTH-1:0] valid_q, valid_d;
  logic [MEM_DEPTH-1:0] isLoad_q, isLoad_d;
  logic [4:0]           rd_q [MEM_DEPTH];
  logic [4:0]           rd_d [MEM_DEPTH];
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 feFlush_q, feFlush_d;
  logic                 icFlushReq_q, icFlushReq_d;
  logic                 sbErr_q, sbErr_d;

  logic raw1, raw2, memOp, full, memBlocked, canIssue, fire, push, pop;

  // Look up both source registers against every pending load in the scoreboard.
  always_comb begin
    raw1 = 1'b0;
    raw2 = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      if (valid_q[i] && isLoad_q[i] && (rd_q[i] == id_rs1)) raw1 = 1'b1;
      if (valid_q[i] && isLoad_q[i] && (rd_q[i] == id_rs2)) raw2 = 1'b1;
    end
    raw1 = raw1 & id_use_rs1 & (id_rs1 != 5'd0);
    raw2 = raw2 & id_use_rs2 & (id_rs2 != 5'd0);
  end

  // Issue decision: a full scoreboard blocks memory ops even if a pop lands this cycle.
  always_comb begin
    memOp      = id_inst_l | id_inst_s;
    full       = (count_q == DEPTH_C);
    memBlocked = full & memOp;
    canIssue   = !rst && (state_q == RUN) && lsu_ready && !raw1 && !raw2 &&
                 !memBlocked && !redirect_valid;
    idu_ready  = canIssue;
    fire       = idu_valid & canIssue;
    exu_issue  = fire;
    hz_stall   = idu_valid & (state_q == RUN) & (raw1 | raw2 | memBlocked);
    push       = fire & memOp;
    pop        = lsu_valid & (count_q != '0);
  end

  // Scoreboard next state: push at the tail, retire at the head, in order.
  always_comb begin
    valid_d  = valid_q;
    isLoad_d = isLoad_q;
    rd_d     = rd_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    sbErr_d  = sbErr_q | (lsu_valid & (count_q == '0));
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (push) begin
      valid_d[tail_q]  = 1'b1;
      isLoad_d[tail_q] = id_inst_l;
      rd_d[tail_q]     = id_inst_l ? id_rd : 5'd0;
      tail_d           = tail_q + PW'(1);
    end
    if (push && !pop) count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Sequencer for redirects and fence.i, plus the registered flush outputs.
  always_comb begin
    state_d      = state_q;
    feFlush_d    = 1'b0;
    icFlushReq_d = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect_valid) state_d = REDIRECT;
        else if (fire && id_is_fence_i) state_d = FENCE_DRAIN;
      end
      REDIRECT: begin
        if (pc_updata) state_d = RUN;
      end
      FENCE_DRAIN: begin
        if (count_d == '0) state_d = FENCE_FLUSH;
      end
      FENCE_FLUSH: begin
        if (ic_flush_ack) begin
          state_d   = RUN;
          feFlush_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (state_d == REDIRECT) feFlush_d = 1'b1;
    icFlushReq_d = (state_d == FENCE_FLUSH);
  end

  // State, scoreboard and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      valid_q      <= '0;
      isLoad_q     <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      feFlush_q    <= 1'b0;
      icFlushReq_q <= 1'b0;
      sbErr_q      <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) rd_q[i] <= 5'd0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      isLoad_q     <= isLoad_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      feFlush_q    <= feFlush_d;
      icFlushReq_q <= icFlushReq_d;
      sbErr_q      <= sbErr_d;
      for (int i = 0; i < MEM_DEPTH; i++) rd_q[i] <= rd_d[i];
    end
  end

  assign fe_flush        = feFlush_q;
  assign ic_flush_req    = icFlushReq_q;
  assign sb_err          = sbErr_q;
  assign mem_outstanding = count_q;

endmodule

// File: tb/tb_ysyx_25020037_hzu.sv
// tb_ysyx_25020037_hzu: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the scheduler.
module tb_ysyx_25020037_hzu;

  localparam int DEPTH = 4;
  localparam int MODE_RUN = 0, MODE_REDIR = 1, MODE_DRAIN = 2, MODE_FLUSH = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       idu_valid, idu_ready;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_inst_l, id_inst_s, id_is_fence_i;
  logic       exu_issue, lsu_ready, lsu_valid, redirect_valid, pc_updata;
  logic       fe_flush, ic_flush_req, ic_flush_ack, hz_stall, sb_err;
  logic [2:0] mem_outstanding;

  // Free-running core clock.
  always #5 clk = ~clk;

  ysyx_25020037_hzu #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .idu_valid(idu_valid), .idu_ready(idu_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_inst_l(id_inst_l), .id_inst_s(id_inst_s), .id_is_fence_i(id_is_fence_i),
    .exu_issue(exu_issue), .lsu_ready(lsu_ready), .lsu_valid(lsu_valid),
    .redirect_valid(redirect_valid), .pc_updata(pc_updata),
    .fe_flush(fe_flush), .ic_flush_req(ic_flush_req), .ic_flush_ack(ic_flush_ack),
    .hz_stall(hz_stall), .mem_outstanding(mem_outstanding), .sb_err(sb_err)
  );

  typedef struct {
    bit isLoad;
    int rd;
  } memEntry_t;

  typedef struct {
    bit       rst, valid, use1, use2, isL, isS, isF;
    bit [4:0] rs1, rs2, rd;
    bit       lsuReady, lsuValid, redirect, pcUp, ack;
  } stim_t;

  memEntry_t pending[$];
  int        mode = MODE_RUN;
  bit        expFe = 0, expIc = 0, expErr = 0;
  int        nVectors = 0, nMiss = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nVectors++;
    if (observed !== expected) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit loadPending(input int r);
    foreach (pending[i]) if (pending[i].isLoad && pending[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.lsuReady = 1'b1;
    return s;
  endfunction

  // One cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic applyStimulus(input stim_t s);
    bit raw1, raw2, memOp, full, expReady, expIssue, expStall, newFe;
    int left;
    @(negedge clk);
    rst = s.rst; idu_valid = s.valid; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
    id_use_rs1 = s.use1; id_use_rs2 = s.use2; id_inst_l = s.isL; id_inst_s = s.isS;
    id_is_fence_i = s.isF; lsu_ready = s.lsuReady; lsu_valid = s.lsuValid;
    redirect_valid = s.redirect; pc_updata = s.pcUp; ic_flush_ack = s.ack;
    #1;
    raw1     = s.use1 && s.rs1 != 0 && loadPending(int'(s.rs1));
    raw2     = s.use2 && s.rs2 != 0 && loadPending(int'(s.rs2));
    memOp    = s.isL || s.isS;
    full     = pending.size() == DEPTH;
    expReady = !s.rst && mode == MODE_RUN && s.lsuReady && !raw1 && !raw2 &&
               !(full && memOp) && !s.redirect;
    expIssue = s.valid && expReady;
    expStall = s.valid && mode == MODE_RUN && (raw1 || raw2 || (full && memOp));
    checkOutput("idu_ready", 32'(idu_ready), 32'(expReady));
    checkOutput("exu_issue", 32'(exu_issue), 32'(expIssue));
    checkOutput("hz_stall", 32'(hz_stall), 32'(expStall));
    checkOutput("fe_flush", 32'(fe_flush), 32'(expFe));
    checkOutput("ic_flush_req", 32'(ic_flush_req), 32'(expIc));
    checkOutput("sb_err", 32'(sb_err), 32'(expErr));
    checkOutput("mem_outstanding", 32'(mem_outstanding), 32'(pending.size()));
    if (s.rst) begin
      pending.delete();
      mode = MODE_RUN; expFe = 0; expIc = 0; expErr = 0;
    end else begin
      newFe = 0;
      if (s.lsuValid && pending.size() == 0) expErr = 1;
      left = pending.size() - ((s.lsuValid && pending.size() > 0) ? 1 : 0);
      case (mode)
        MODE_RUN:   if (s.redirect) mode = MODE_REDIR;
                    else if (expIssue && s.isF) mode = MODE_DRAIN;
        MODE_REDIR: if (s.pcUp) mode = MODE_RUN;
        MODE_DRAIN: if (left == 0) mode = MODE_FLUSH;
        default:    if (s.ack) begin mode = MODE_RUN; newFe = 1; end
      endcase
      if (s.lsuValid && pending.size() > 0) void'(pending.pop_front());
      if (expIssue && memOp) pending.push_back('{isLoad: s.isL, rd: s.isL ? int'(s.rd) : 0});
      expFe = newFe || mode == MODE_REDIR;
      expIc = mode == MODE_FLUSH;
    end
    @(posedge clk);
  endtask

  initial begin
    stim_t s;
    rst = 1; idu_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_inst_l = 0; id_inst_s = 0; id_is_fence_i = 0;
    lsu_ready = 1; lsu_valid = 0; redirect_valid = 0; pc_updata = 0; ic_flush_ack = 0;
    @(posedge clk); @(posedge clk);
    s = idle(); s.rst = 1; applyStimulus(s);
    applyStimulus(idle());

    // Load x5, then dependent add stalls until the load retires.
    s = idle(); s.valid = 1; s.isL = 1; s.rd = 5; applyStimulus(s);
    s = idle(); s.valid = 1; s.use1 = 1; s.use2 = 1; s.rs1 = 5; s.rs2 = 1; s.rd = 6;
    repeat (3) applyStimulus(s);
    s.lsuValid = 1; applyStimulus(s);
    s.lsuValid = 0; applyStimulus(s);
    applyStimulus(idle());

    // Fill the scoreboard with stores; the 5th op waits past the pop cycle.
    s = idle(); s.valid = 1; s.isS = 1; s.rs1 = 2; s.use1 = 1;
    repeat (4) applyStimulus(s);
    applyStimulus(s);
    s.lsuValid = 1; applyStimulus(s);
    s.lsuValid = 0; applyStimulus(s);
    s = idle(); s.lsuValid = 1; repeat (4) applyStimulus(s);

    // Redirect together with a valid ALU op, PC reload after three flush cycles.
    s = idle(); s.valid = 1; s.rs1 = 3; s.use1 = 1; s.rd = 4; s.redirect = 1; applyStimulus(s);
    s.redirect = 0; applyStimulus(s); applyStimulus(s);
    s.pcUp = 1; applyStimulus(s);
    s.pcUp = 0; applyStimulus(s);

    // fence.i with two loads outstanding, acked five cycles into the flush.
    s = idle(); s.valid = 1; s.isL = 1; s.rd = 7; applyStimulus(s);
    s.rd = 8; applyStimulus(s);
    s = idle(); s.valid = 1; s.isF = 1; applyStimulus(s);
    s = idle(); s.valid = 1; applyStimulus(s);
    s.lsuValid = 1; applyStimulus(s);
    s.lsuValid = 0; applyStimulus(s);
    s.lsuValid = 1; applyStimulus(s);
    s.lsuValid = 0; repeat (5) applyStimulus(s);
    s.ack = 1; applyStimulus(s);
    s.ack = 0; applyStimulus(s); applyStimulus(s);

    // Simultaneous push and pop at count 2, then wrap the pointers with dependents.
    s = idle(); s.valid = 1; s.isS = 1; applyStimulus(s); applyStimulus(s);
    s.lsuValid = 1; applyStimulus(s);
    s = idle(); s.lsuValid = 1; applyStimulus(s); applyStimulus(s);
    for (int i = 0; i < 10; i++) begin
      s = idle(); s.valid = 1; s.isL = 1; s.rd = 5'(i + 1); s.lsuValid = (pending.size() >= 2);
      applyStimulus(s);
      s = idle(); s.valid = 1; s.use2 = 1; s.rs2 = 5'(i + 1); applyStimulus(s);
    end
    s = idle(); s.lsuValid = 1; repeat (3) applyStimulus(s);

    // Reset in the middle of the flush, then a stray retire.
    s = idle(); s.valid = 1; s.isL = 1; s.rd = 9; applyStimulus(s);
    s = idle(); s.valid = 1; s.isF = 1; applyStimulus(s);
    s = idle(); s.lsuValid = 1; applyStimulus(s);
    s = idle(); applyStimulus(s);
    s.rst = 1; applyStimulus(s);
    s.rst = 0; applyStimulus(s);
    s.lsuValid = 1; applyStimulus(s);
    s.lsuValid = 0; applyStimulus(s); applyStimulus(s);
    s.rst = 1; applyStimulus(s);

    // Random traffic over a small register set so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      int cls;
      s = idle();
      s.rst      = ($urandom_range(0, 199) == 0);
      s.valid    = ($urandom_range(0, 9) < 8);
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.rd       = 5'($urandom_range(0, 3));
      s.use1     = $urandom_range(0, 1);
      s.use2     = $urandom_range(0, 1);
      cls        = $urandom_range(0, 19);
      s.isL      = (cls < 6);
      s.isS      = (cls >= 6 && cls < 10);
      s.isF      = (cls == 10);
      s.lsuReady = ($urandom_range(0, 9) < 9);
      s.lsuValid = (pending.size() > 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) == 0);
      s.redirect = ($urandom_range(0, 29) == 0);
      s.pcUp     = ($urandom_range(0, 9) < 3);
      s.ack      = ($urandom_range(0, 9) < 3);
      applyStimulus(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
